// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: per-cycle hold/flush controls, data-memory wait FSM and stats.
// Controls are combinational (effective at next edge); a data-memory wait freezes the whole pipe until ready or timeout.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_dest,
  input  logic             mem_memread,
  input  logic [4:0]       mem_dest,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             stat_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic {RUN, WAIT} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           err_set;
  logic           match_ex, match_mem;
  logic           load_use, br_hz, abort, mem_stall, redirect_hon;

  // Register 0 is hardwired, so a zero destination can never create a hazard.
  always_comb begin
    match_ex  = (ex_dest != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
    match_mem = (mem_dest != 5'd0) &&
                ((id_uses_rs && (id_rs == mem_dest)) || (id_uses_rt && (id_rt == mem_dest)));
  end

  assign load_use     = ex_memread && match_ex;
  assign br_hz        = id_branch && ((ex_regwrite && match_ex) || (mem_memread && match_mem));
  assign abort        = (state == WAIT) && (wait_cnt == WAIT_LAST);
  assign mem_stall    = dmem_req && !dmem_ready && !abort;
  assign redirect_hon = ex_redirect && !mem_stall;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        // Redirect is left alone here; ID/EX is held so it re-presents later.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use || br_hz) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      WAIT: begin
        if (dmem_ready || !dmem_req) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (abort) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          err_set      = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) mem_timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (redirect_hon && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with a small timeout and narrow counters to reach the boundaries quickly.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] C_IDLE  = 7'b1101010;
  localparam logic [6:0] C_LDUSE = 7'b0001110;
  localparam logic [6:0] C_REDIR = 7'b1111110;
  localparam logic [6:0] C_MEMST = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic id_uses_rs, id_uses_rt, id_branch, ex_memread, ex_regwrite, mem_memread;
  logic ex_redirect, dmem_req, dmem_ready, stat_clr;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0] ctrl, exp;
  logic [6:0] sb[$];
  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_dest(ex_dest), .mem_memread(mem_memread), .mem_dest(mem_dest),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stat_clr(stat_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dest = 5'd0;
    mem_memread = 1'b0; mem_dest = 5'd0; ex_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dest = r; id_uses_rs = 1'b1; id_rs = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_load_use(5'd8);
    ex_redirect = 1'b1; dmem_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(C_IDLE);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, exp); end
      next_cycle();
    end
    checks++;
    if ({mem_timeout_err, stall_cycles, flush_count} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state err=%b stall=%0d flush=%0d exp=0/0/0", mem_timeout_err, stall_cycles, flush_count);
    end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_data_hazards();
    // load-use, register-0 immunity, branch on ALU result in EX, branch on load in MEM
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin set_load_use(5'd8); sb.push_back(C_LDUSE); end
        1: begin set_load_use(5'd0); sb.push_back(C_IDLE); end
        2: begin id_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd9;
                 ex_regwrite = 1'b1; ex_dest = 5'd9; sb.push_back(C_LDUSE); end
        3: begin id_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd9;
                 mem_memread = 1'b1; mem_dest = 5'd9; sb.push_back(C_LDUSE); end
        default: begin id_uses_rs = 1'b1; id_rs = 5'd9;
                 mem_memread = 1'b1; mem_dest = 5'd9; sb.push_back(C_IDLE); end
      endcase
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL hazard_%0d got=%b exp=%b", i, ctrl, exp); end
      next_cycle();
    end
    idle();
    checks++;
    if (stall_cycles !== 4'd3) begin failures++; $display("FAIL stall_after_hazards got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_redirect_priority();
    idle();
    set_load_use(5'd8);
    ex_redirect = 1'b1;
    sb.push_back(C_REDIR);
    @(negedge clk);
    exp = sb.pop_front(); checks++;
    if (ctrl !== exp) begin failures++; $display("FAIL redirect_over_load got=%b exp=%b", ctrl, exp); end
    next_cycle();
    idle();
    checks++;
    if ({stall_cycles, flush_count} !== {4'd3, 4'd1}) begin
      failures++; $display("FAIL redirect_counts stall=%0d flush=%0d exp=3/1", stall_cycles, flush_count);
    end
  endtask

  task automatic test_mem_wait();
    idle();
    dmem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dmem_ready = (i >= 3);
      if (i == 4) ex_redirect = 1'b0;
      sb.push_back(i < 3 ? C_MEMST : (i == 3 ? C_REDIR : C_IDLE));
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL mem_wait_%0d got=%b exp=%b", i, ctrl, exp); end
      next_cycle();
    end
    idle();
    checks++;
    if ({mem_timeout_err, stall_cycles, flush_count} !== {1'b0, 4'd6, 4'd2}) begin
      failures++;
      $display("FAIL mem_wait_state err=%b stall=%0d flush=%0d exp=0/6/2", mem_timeout_err, stall_cycles, flush_count);
    end
  endtask

  task automatic test_timeout();
    idle();
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back((i == 3) ? C_IDLE : C_MEMST);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL timeout_%0d got=%b exp=%b", i, ctrl, exp); end
      next_cycle();
    end
    idle();
    next_cycle();
    checks++;
    if (mem_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout_err); end
    // enter WAIT, then reset mid-wait: must come back to RUN with a fresh count and no error
    dmem_req = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    sb.push_back(C_IDLE);
    @(negedge clk);
    exp = sb.pop_front(); checks++;
    if (ctrl !== exp) begin failures++; $display("FAIL reset_forces_ctrl got=%b exp=%b", ctrl, exp); end
    next_cycle();
    reset = 1'b0;
    checks++;
    if (mem_timeout_err !== 1'b0) begin failures++; $display("FAIL reset_clears_err got=%b exp=0", mem_timeout_err); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back((i == 3) ? C_IDLE : C_MEMST);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL post_reset_wait_%0d got=%b exp=%b", i, ctrl, exp); end
      next_cycle();
    end
    idle();
    checks++;
    if (mem_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_again got=%b exp=1", mem_timeout_err); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checks++;
    if ({mem_timeout_err, stall_cycles, flush_count} !== 9'd0) begin
      failures++;
      $display("FAIL final_reset err=%b stall=%0d flush=%0d exp=0/0/0", mem_timeout_err, stall_cycles, flush_count);
    end
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 32; i++) begin
      idle();
      if (i < 16) begin set_load_use(5'd3); sb.push_back(C_LDUSE); end
      else begin ex_redirect = 1'b1; sb.push_back(C_REDIR); end
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (ctrl !== exp) begin failures++; $display("FAIL sat_ctrl_%0d got=%b exp=%b", i, ctrl, exp); end
      next_cycle();
    end
    idle();
    checks++;
    if ({stall_cycles, flush_count} !== {4'd15, 4'd15}) begin
      failures++; $display("FAIL saturate stall=%0d flush=%0d exp=15/15", stall_cycles, flush_count);
    end
    ex_redirect = 1'b1; stat_clr = 1'b1;
    next_cycle();
    idle();
    checks++;
    if ({stall_cycles, flush_count} !== 8'd0) begin
      failures++; $display("FAIL stat_clr stall=%0d flush=%0d exp=0/0", stall_cycles, flush_count);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_data_hazards();
    test_redirect_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    if (sb.size() != 0) begin
      failures++; checks++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
